// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the IO bus master-side arbiter: FSM encoding, ctrl bit layout,
// default device-select field position and a width helper.
package io_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WR   = 3'd2,
        ST_RD1  = 3'd3,
        ST_RD2  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    localparam int unsigned WE_BIT        = 0;
    localparam logic        IO_CTRL_WRITE = 1'b1;
    localparam logic        IO_CTRL_READ  = 1'b0;

    localparam int unsigned DEV_HI_DEFAULT = 15;
    localparam int unsigned DEV_LO_DEFAULT = 12;

    // Index width for an n-entry vector, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module io_bus_arbiter_rr_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    localparam int unsigned IDX_W     = idx_width(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]     idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < N_MASTERS; off++) begin
            cand = (32'(ptr) + off) % N_MASTERS;
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                grant[IDX_W'(cand)]  = 1'b1;
                idx                  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shared IO bus master: round-robin arbitration, bus sequencing, device decode to one-hot bg.
// Optional macro IO_ARB_DECERR_EN: out-of-range device field returns an error ack instead of aliasing.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned N_DEVICES = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CTRL_W    = 2,
    parameter int unsigned DEV_HI    = DEV_HI_DEFAULT,
    parameter int unsigned DEV_LO    = DEV_LO_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS-1:0]        m_we,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]        m_ack,
    output logic [N_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [CTRL_W-1:0]           bus_ctrl,
    output logic [DATA_W-1:0]           bus_dout,
    output logic                        bus_oe,
    input  logic [DATA_W-1:0]           bus_din,
    output logic [N_DEVICES-1:0]        bg
);

    localparam int unsigned IDX_W = idx_width(N_MASTERS);
    localparam int unsigned SEL_W = idx_width(N_DEVICES);

    state_t state, state_next;

    logic [IDX_W-1:0]     rr_ptr, winner, grant_idx;
    logic [N_MASTERS-1:0] grant, win_oh;
    logic [ADDR_W-1:0]    addr_q, sel_addr;
    logic [DATA_W-1:0]    wdata_q, sel_wdata;
    logic                 we_q, sel_we;
    logic [SEL_W-1:0]     dev;
    logic                 dec_err;

    logic [N_DEVICES-1:0] bg_d;
    logic                 bus_oe_d;
    logic [CTRL_W-1:0]    bus_ctrl_d;
    logic [ADDR_W-1:0]    bus_addr_d;
    logic [DATA_W-1:0]    bus_dout_d;
    logic [N_MASTERS-1:0] m_ack_d, m_err_d;

    io_bus_arbiter_rr_arbiter #(.N_MASTERS(N_MASTERS)) u_rr (
        .req   (m_req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Mux the winning master's request fields out of the packed buses.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                sel_we    = m_we[i];
            end
        end
    end

    assign dev = addr_q[DEV_LO +: SEL_W];

`ifdef IO_ARB_DECERR_EN
    assign dec_err = (32'(addr_q[DEV_HI:DEV_LO]) >= N_DEVICES);
`else
    assign dec_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (|m_req) state_next = ST_ADDR;
            ST_ADDR: begin
                if (dec_err)   state_next = ST_RESP;
                else if (we_q) state_next = ST_WR;
                else           state_next = ST_RD1;
            end
            ST_WR:   state_next = ST_RESP;
            ST_RD1:  state_next = ST_RD2;
            ST_RD2:  state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so registered outputs line up with the state.
    always_comb begin
        bg_d       = '0;
        bus_oe_d   = 1'b0;
        bus_ctrl_d = '0;
        bus_addr_d = '0;
        bus_dout_d = '0;
        m_ack_d    = '0;
        m_err_d    = '0;
        case (state_next)
            ST_ADDR: begin
                // Only reachable from IDLE, where the request is still on the master ports.
                bus_addr_d         = sel_addr;
                bus_ctrl_d[WE_BIT] = sel_we ? IO_CTRL_WRITE : IO_CTRL_READ;
            end
            ST_WR: begin
                bus_addr_d         = addr_q;
                bus_ctrl_d[WE_BIT] = IO_CTRL_WRITE;
                bg_d[dev]          = 1'b1;
                bus_oe_d           = 1'b1;
                bus_dout_d         = wdata_q;
            end
            ST_RD1, ST_RD2: begin
                bus_addr_d         = addr_q;
                bus_ctrl_d[WE_BIT] = IO_CTRL_READ;
                bg_d[dev]          = 1'b1;
            end
            ST_RESP: begin
                m_ack_d = win_oh;
                m_err_d = dec_err ? win_oh : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bg       <= '0;
            bus_oe   <= 1'b0;
            bus_ctrl <= '0;
            bus_addr <= '0;
            bus_dout <= '0;
            m_ack    <= '0;
            m_err    <= '0;
        end else begin
            bg       <= bg_d;
            bus_oe   <= bus_oe_d;
            bus_ctrl <= bus_ctrl_d;
            bus_addr <= bus_addr_d;
            bus_dout <= bus_dout_d;
            m_ack    <= m_ack_d;
            m_err    <= m_err_d;
        end
    end

    // Transaction capture; masters are free to change their inputs after this.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            winner  <= '0;
            win_oh  <= '0;
        end else if (state == ST_IDLE && |m_req) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            winner  <= grant_idx;
            win_oh  <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == ST_RESP) begin
            rr_ptr <= (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Read data persists across writes; an error response clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rdata <= '0;
        end else if (state == ST_RD2) begin
            m_rdata <= bus_din;
        end else if (state == ST_ADDR && dec_err) begin
            m_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with an ack scoreboard; honours IO_ARB_DECERR_EN when defined.
module tb_io_bus_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned ND = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [NM-1:0] oh;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_req, m_we, m_ack, m_err;
    logic [AW-1:0]     addr_arr  [NM];
    logic [DW-1:0]     wdata_arr [NM];
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [DW-1:0]     m_rdata, bus_dout, bus_din;
    logic [AW-1:0]     bus_addr;
    logic [CW-1:0]     bus_ctrl;
    logic              bus_oe;
    logic [ND-1:0]     bg;

    int   checks   = 0;
    int   failures = 0;
    logic mon_on   = 1'b0;
    exp_t exp_q[$];
    logic [DW-1:0] model_rdata = '0;

    assign m_addr  = {addr_arr[1], addr_arr[0]};
    assign m_wdata = {wdata_arr[1], wdata_arr[0]};

    always #5 clk = ~clk;

    io_bus_arbiter #(
        .N_MASTERS(NM), .N_DEVICES(ND), .ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW),
        .DEV_HI(15), .DEV_LO(12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .bus_addr (bus_addr),
        .bus_ctrl (bus_ctrl),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din),
        .bg       (bg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: bg invariant every cycle, and every ack is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_on) begin
            check("bg_onehot0", 32'($onehot0(bg)), 32'd1);
            if (m_ack != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got m_ack=0x%0h expected none", m_ack);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_master", 32'(m_ack), 32'(e.oh));
                    check("ack_err",    32'(m_err), e.err ? 32'(e.oh) : 32'd0);
                    check("ack_rdata",  m_rdata,    e.rdata);
                end
            end
        end
    end

    // One transaction from a single master, checked phase by phase on the bus.
    task automatic run_txn(input logic m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] din, input logic drop_early);
        logic       err;
        logic [3:0] ebg;
        exp_t       e;
`ifdef IO_ARB_DECERR_EN
        err = (addr[15:12] >= 4'd4);
`else
        err = 1'b0;
`endif
        ebg          = err ? 4'b0000 : (4'b0001 << addr[13:12]);
        bus_din      = din;
        m_req[m]     = 1'b1;
        m_we[m]      = we;
        addr_arr[m]  = addr;
        wdata_arr[m] = wdata;
        if (err)      model_rdata = '0;
        else if (!we) model_rdata = din;
        e.oh    = NM'(1) << m;
        e.err   = err;
        e.rdata = model_rdata;
        exp_q.push_back(e);

        @(negedge clk);
        check("addr_phase_addr", bus_addr, addr);
        check("addr_phase_we",   32'(bus_ctrl), 32'(we));
        check("addr_phase_bg",   32'(bg), 32'd0);
        check("addr_phase_oe",   32'(bus_oe), 32'd0);
        if (drop_early) m_req[m] = 1'b0;
        addr_arr[m]  = 32'hFFFF_FFFF;
        wdata_arr[m] = 32'h0;

        if (!err) begin
            if (we) begin
                @(negedge clk);
                check("wr_bg",   32'(bg), 32'(ebg));
                check("wr_oe",   32'(bus_oe), 32'd1);
                check("wr_dout", bus_dout, wdata);
            end else begin
                @(negedge clk);
                check("rd1_bg", 32'(bg), 32'(ebg));
                check("rd1_oe", 32'(bus_oe), 32'd0);
                @(negedge clk);
                check("rd2_bg", 32'(bg), 32'(ebg));
                check("rd2_oe", 32'(bus_oe), 32'd0);
            end
        end

        @(negedge clk);
        check("resp_ack_latency", 32'(m_ack[m]), 32'd1);
        check("resp_bg",          32'(bg), 32'd0);
        check("resp_oe",          32'(bus_oe), 32'd0);
        m_req[m] = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(m_ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_acks;
        int   ack_at [4];
        exp_t e;

        rst          = 1'b1;
        m_req        = '0;
        m_we         = '0;
        addr_arr[0]  = '0;
        addr_arr[1]  = '0;
        wdata_arr[0] = '0;
        wdata_arr[1] = '0;
        bus_din      = '0;
        repeat (2) @(negedge clk);
        mon_on = 1'b1;

        check("rst_ack",      32'(m_ack), 32'd0);
        check("rst_err",      32'(m_err), 32'd0);
        check("rst_bg",       32'(bg), 32'd0);
        check("rst_oe",       32'(bus_oe), 32'd0);
        check("rst_ctrl",     32'(bus_ctrl), 32'd0);
        check("rst_addr",     bus_addr, 32'd0);
        check("rst_dout",     bus_dout, 32'd0);
        check("rst_rdata",    m_rdata, 32'd0);
        rst = 1'b0;

        run_txn(1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0,         32'h1234_5678, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 32'h0, 1'b0);
        run_txn(1'b0, 1'b0, 32'h0000_7000, 32'h0,         32'hCAFE_F00D, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_0004, 32'h0F0F_0F0F, 32'h0, 1'b1);

        // Reset while the read sits in RD1: no ack, everything back to zero.
        bus_din     = 32'h55AA_55AA;
        m_req[1]    = 1'b1;
        m_we[1]     = 1'b0;
        addr_arr[1] = 32'h0000_2000;
        @(negedge clk);
        @(negedge clk);
        check("rd1_before_rst_bg", 32'(bg), 32'h4);
        rst         = 1'b1;
        model_rdata = '0;
        @(negedge clk);
        check("post_rst_bg",    32'(bg), 32'd0);
        check("post_rst_ack",   32'(m_ack), 32'd0);
        check("post_rst_addr",  bus_addr, 32'd0);
        check("post_rst_ctrl",  32'(bus_ctrl), 32'd0);
        check("post_rst_rdata", m_rdata, 32'd0);
        rst      = 1'b0;
        m_req[1] = 1'b0;
        run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Contention from reset: both masters hold requests; acks must alternate 0,1,0,1.
        rst          = 1'b1;
        addr_arr[0]  = 32'h0000_3008;
        wdata_arr[0] = 32'h1111_1111;
        addr_arr[1]  = 32'h0000_0010;
        wdata_arr[1] = 32'h2222_2222;
        m_we         = 2'b11;
        m_req        = 2'b11;
        model_rdata  = '0;
        for (int i = 0; i < 4; i++) begin
            e.oh    = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.err   = 1'b0;
            e.rdata = model_rdata;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rst    = 1'b0;
        n_acks = 0;
        for (int i = 0; i < 4; i++) ack_at[i] = 0;
        for (int c = 1; c <= 40 && n_acks < 4; c++) begin
            @(negedge clk);
            if (m_ack != '0) begin
                ack_at[n_acks] = c;
                n_acks++;
            end
        end
        m_req = '0;
        check("contention_ack_count", 32'(n_acks), 32'd4);
        check("contention_first_ack", 32'(ack_at[0]), 32'd3);
        for (int i = 1; i < 4; i++)
            check("contention_spacing", 32'(ack_at[i] - ack_at[i-1]), 32'd4);

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
